cpu_program_checker: RTL and testbench

- Synthesizable, parametrised program-replay and self-check engine for the tiny tensor core CPU.
- Fetches instructions from a program ROM and issues each one to the CPU as a single-cycle pulse.
- After a configurable settle time, compares a selected CPU register and the ALU flags against an expected-value ROM, and accumulates test/pass/fail counts.
- Sits beside the cpu instance as an on-chip BIST controller, so regression programs run on FPGA without a simulator.

---
 rtl/cpu_checker_pkg.sv | 43 ++++
 rtl/saturating_counter.sv | 23 ++
 rtl/cpu_program_checker.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu_program_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_checker_pkg.sv
// Shared types and field layout for the program-replay self-check engine.
package cpu_checker_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // ALU flag vector layout: {parity, overflow, carry, zero, sign}.
  localparam int unsigned NUM_FLAGS = 5;
  localparam int unsigned FLAG_P    = 4;
  localparam int unsigned FLAG_O    = 3;
  localparam int unsigned FLAG_C    = 2;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned FLAG_S    = 0;

  // Check word, MSB first: {check_en, reg_idx, expected, flag_mask, expected_flags}.
  localparam int unsigned EXP_FLAGS_LSB = 0;
  localparam int unsigned FLAG_MASK_LSB = EXP_FLAGS_LSB + NUM_FLAGS;
  localparam int unsigned EXPECTED_LSB  = FLAG_MASK_LSB + NUM_FLAGS;

  // Register index field width; a single-register bus still carries one index bit.
  function automatic int unsigned reg_idx_w(input int unsigned num_registers);
    return (num_registers > 1) ? $clog2(num_registers) : 1;
  endfunction

  // Bit offset of the register index field.
  function automatic int unsigned reg_idx_lsb(input int unsigned data_width);
    return EXPECTED_LSB + data_width;
  endfunction

  // Total check word width.
  function automatic int unsigned check_w(input int unsigned num_registers,
                                          input int unsigned data_width);
    return 1 + reg_idx_w(num_registers) + data_width + 2 * NUM_FLAGS;
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  // Clear has priority; increment stops at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_program_checker.sv
// Program-replay BIST controller: fetches instructions from a ROM, issues each
// once to the CPU, then checks a selected register and the flags against a
// check ROM sharing the same address, accumulating test/pass/fail counts.
module cpu_program_checker
  import cpu_checker_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 4,
  parameter  int unsigned NUM_REGISTERS = 8,
  parameter  int unsigned INSTR_WIDTH   = 32,
  parameter  int unsigned PROGRAM_DEPTH = 1024,
  parameter  int unsigned CHECK_LATENCY = 2,
  parameter  int unsigned COUNT_WIDTH   = 16,
  localparam int unsigned ADDR_WIDTH    = (PROGRAM_DEPTH > 1) ? $clog2(PROGRAM_DEPTH) : 1,
  localparam int unsigned CHECK_W       = check_w(NUM_REGISTERS, DATA_WIDTH)
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  input  logic                              start_in,
  input  logic                              stop_on_fail_in,
  output logic [ADDR_WIDTH-1:0]             prog_addr_out,
  input  logic [INSTR_WIDTH-1:0]            prog_data_in,
  input  logic [CHECK_W-1:0]                check_data_in,
  output logic [INSTR_WIDTH-1:0]            current_instruction_out,
  output logic                              instruction_valid_out,
  input  logic [NUM_REGISTERS*DATA_WIDTH-1:0] registers_in,
  input  logic [NUM_FLAGS-1:0]              flags_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [COUNT_WIDTH-1:0]            test_count_out,
  output logic [COUNT_WIDTH-1:0]            pass_count_out,
  output logic [COUNT_WIDTH-1:0]            fail_count_out,
  output logic                              first_fail_valid_out,
  output logic [ADDR_WIDTH-1:0]             first_fail_addr_out
);

  localparam int unsigned IDX_W    = reg_idx_w(NUM_REGISTERS);
  localparam int unsigned IDX_LSB  = reg_idx_lsb(DATA_WIDTH);
  localparam int unsigned SETTLE_W = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY + 1) : 1;
  localparam int unsigned LAST_PC  = PROGRAM_DEPTH - 1;

  // Registered state.
  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic                     stop_q, stop_d;
  logic [CHECK_W-1:0]       check_q, check_d;
  logic [SETTLE_W-1:0]      settle_q, settle_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ff_valid_q, ff_valid_d;
  logic [ADDR_WIDTH-1:0]    ff_addr_q, ff_addr_d;

  // Counter controls.
  logic                     clear_cnt;
  logic                     test_inc;
  logic                     pass_inc;
  logic                     fail_inc;

  // Fields of the latched check word.
  logic                     chk_en;
  logic [IDX_W-1:0]         chk_idx;
  logic [DATA_WIDTH-1:0]    chk_expected;
  logic [NUM_FLAGS-1:0]     chk_mask;
  logic [NUM_FLAGS-1:0]     chk_eflags;

  // Evaluation of the current check.
  logic [DATA_WIDTH-1:0]    sel_reg;
  logic                     idx_ok;
  logic                     reg_match;
  logic                     flags_match;
  logic                     check_pass;
  logic                     at_last_pc;

  assign chk_en       = check_q[CHECK_W-1];
  assign chk_idx      = check_q[IDX_LSB +: IDX_W];
  assign chk_expected = check_q[EXPECTED_LSB +: DATA_WIDTH];
  assign chk_mask     = check_q[FLAG_MASK_LSB +: NUM_FLAGS];
  assign chk_eflags   = check_q[EXP_FLAGS_LSB +: NUM_FLAGS];

  // Register r sits at the top of the flattened bus for r = 0.
  always_comb begin
    sel_reg = '0;
    for (int unsigned r = 0; r < NUM_REGISTERS; r++) begin
      if (32'(chk_idx) == r) begin
        sel_reg = registers_in[(NUM_REGISTERS - 1 - r) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // An out-of-range index is always a failure.
  assign idx_ok      = (32'(chk_idx) < NUM_REGISTERS);
  assign reg_match   = (sel_reg == chk_expected);
  assign flags_match = (((flags_in ^ chk_eflags) & chk_mask) == '0);
  assign check_pass  = idx_ok && reg_match && flags_match;
  assign at_last_pc  = (pc_q == ADDR_WIDTH'(LAST_PC));

  // Next-state, datapath and counter-control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stop_d     = stop_q;
    check_d    = check_q;
    settle_d   = settle_q;
    instr_d    = '0;
    valid_d    = 1'b0;
    ff_valid_d = ff_valid_q;
    ff_addr_d  = ff_addr_q;
    clear_cnt  = 1'b0;
    test_inc   = 1'b0;
    pass_inc   = 1'b0;
    fail_inc   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          clear_cnt  = 1'b1;
          pc_d       = '0;
          ff_valid_d = 1'b0;
          ff_addr_d  = '0;
          stop_d     = stop_on_fail_in;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        // An all-zero word ends the program without being issued or counted.
        if (prog_data_in == '0) begin
          state_d = ST_DONE;
        end else begin
          instr_d  = prog_data_in;
          valid_d  = 1'b1;
          check_d  = check_data_in;
          settle_d = SETTLE_W'(CHECK_LATENCY);
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settle_q <= SETTLE_W'(1)) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      ST_CHECK: begin
        if (chk_en) begin
          test_inc = 1'b1;
          pass_inc = check_pass;
          fail_inc = !check_pass;
          if (!check_pass && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_addr_d  = pc_q;
          end
        end
        if (at_last_pc || (fail_inc && stop_q)) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      stop_q     <= 1'b0;
      check_q    <= '0;
      settle_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ff_valid_q <= 1'b0;
      ff_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stop_q     <= stop_d;
      check_q    <= check_d;
      settle_q   <= settle_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ff_valid_q <= ff_valid_d;
      ff_addr_q  <= ff_addr_d;
    end
  end

  assign prog_addr_out           = pc_q;
  assign current_instruction_out = instr_q;
  assign instruction_valid_out   = valid_q;
  assign busy_out                = busy_q;
  assign done_out                = done_q;
  assign first_fail_valid_out    = ff_valid_q;
  assign first_fail_addr_out     = ff_addr_q;

  saturating_counter #(.WIDTH(COUNT_WIDTH)) u_test_count (
    .clk       (clock_in),
    .rst       (reset_in),
    .clear     (clear_cnt),
    .increment (test_inc),
    .count     (test_count_out)
  );

  saturating_counter #(.WIDTH(COUNT_WIDTH)) u_pass_count (
    .clk       (clock_in),
    .rst       (reset_in),
    .clear     (clear_cnt),
    .increment (pass_inc),
    .count     (pass_count_out)
  );

  saturating_counter #(.WIDTH(COUNT_WIDTH)) u_fail_count (
    .clk       (clock_in),
    .rst       (reset_in),
    .clear     (clear_cnt),
    .increment (fail_inc),
    .count     (fail_count_out)
  );

endmodule

// File: tb/tb_cpu_program_checker.sv
// Directed bench: ROM models, a tiny add-immediate CPU model and hand-computed results.
module tb_cpu_program_checker;

  localparam int unsigned DW    = 4;
  localparam int unsigned NR    = 8;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CL    = 2;
  localparam int unsigned CW    = 2;
  localparam int unsigned AW    = 2;
  localparam int unsigned CKW   = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop_on_fail;
  logic [AW-1:0]     prog_addr;
  logic [IW-1:0]     prog_data;
  logic [CKW-1:0]    check_data;
  logic [IW-1:0]     cur_instr;
  logic              instr_valid;
  logic [NR*DW-1:0]  registers;
  logic [4:0]        cpu_flags;
  logic              busy;
  logic              done;
  logic [CW-1:0]     test_count;
  logic [CW-1:0]     pass_count;
  logic [CW-1:0]     fail_count;
  logic              ff_valid;
  logic [AW-1:0]     ff_addr;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int issue_count = 0;
  int issue_cyc [8];

  logic [IW-1:0]  prog_mem [DEPTH];
  logic [CKW-1:0] chk_mem  [DEPTH];
  logic [DW-1:0]  regs     [NR];

  cpu_program_checker #(
    .DATA_WIDTH   (DW),
    .NUM_REGISTERS(NR),
    .INSTR_WIDTH  (IW),
    .PROGRAM_DEPTH(DEPTH),
    .CHECK_LATENCY(CL),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock_in               (clk),
    .reset_in               (rst),
    .start_in               (start),
    .stop_on_fail_in        (stop_on_fail),
    .prog_addr_out          (prog_addr),
    .prog_data_in           (prog_data),
    .check_data_in          (check_data),
    .current_instruction_out(cur_instr),
    .instruction_valid_out  (instr_valid),
    .registers_in           (registers),
    .flags_in               (cpu_flags),
    .busy_out               (busy),
    .done_out               (done),
    .test_count_out         (test_count),
    .pass_count_out         (pass_count),
    .fail_count_out         (fail_count),
    .first_fail_valid_out   (ff_valid),
    .first_fail_addr_out    (ff_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    prog_data  <= prog_mem[prog_addr];
    check_data <= chk_mem[prog_addr];
  end

  // CPU model: opcode 8'h01 is rd = rs + imm.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (instr_valid && cur_instr[31:24] == 8'h01) begin
      regs[cur_instr[22:20]] <= regs[cur_instr[18:16]] + cur_instr[3:0];
    end
  end

  always_comb begin
    registers = '0;
    for (int r = 0; r < NR; r++) registers[(NR - 1 - r) * DW +: DW] = regs[r];
  end

  // Record issue pulses and the cycle each one appeared.
  always @(negedge clk) begin
    if (instr_valid) begin
      if (issue_count < 8) issue_cyc[issue_count] = cycle;
      issue_count = issue_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] addi(input int rd, input int rs, input int imm);
    return {8'h01, 1'b0, 3'(rd), 1'b0, 3'(rs), 12'h000, 4'(imm)};
  endfunction

  function automatic logic [CKW-1:0] chk(input int en, input int idx, input int exp,
                                         input int mask, input int ef);
    return {1'(en), 3'(idx), 4'(exp), 5'(mask), 5'(ef)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      prog_mem[i] = '0;
      chk_mem[i]  = '0;
    end
  endtask

  task automatic start_run(input logic sof);
    @(negedge clk);
    issue_count  = 0;
    stop_on_fail = sof;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic load_two_step();
    clear_mem();
    prog_mem[0] = addi(1, 0, 5);
    chk_mem[0]  = chk(1, 1, 5, 0, 0);
    prog_mem[1] = addi(2, 1, 10);
    chk_mem[1]  = chk(1, 2, 15, 0, 0);
  endtask

  task automatic load_three_step(input int exp1);
    clear_mem();
    prog_mem[0] = addi(1, 0, 5);
    chk_mem[0]  = chk(1, 1, 5, 0, 0);
    prog_mem[1] = addi(2, 1, 1);
    chk_mem[1]  = chk(1, 2, exp1, 0, 0);
    prog_mem[2] = addi(3, 2, 1);
    chk_mem[2]  = chk(1, 3, 7, 0, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; stop_on_fail = 1'b0; cpu_flags = '0;
    clear_mem();
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", cur_instr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(prog_addr), 32'd0);
    check("rst_test", 32'(test_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two-instruction program ending with a zero word.
    load_two_step();
    start_run(1'b0);
    wait_done("t1");
    check("t1_test", 32'(test_count), 32'd2);
    check("t1_pass", 32'(pass_count), 32'd2);
    check("t1_fail", 32'(fail_count), 32'd0);
    check("t1_ffv", 32'(ff_valid), 32'd0);
    check("t1_issues", 32'(issue_count), 32'd2);
    check("t1_gap", 32'(issue_cyc[1] - issue_cyc[0]), 32'd5);
    check("t1_addr", 32'(prog_addr), 32'd2);

    // Wrong expectation on entry 1, run continues; a start while busy is ignored.
    load_three_step(7);
    start_run(1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2");
    check("t2_test", 32'(test_count), 32'd3);
    check("t2_pass", 32'(pass_count), 32'd2);
    check("t2_fail", 32'(fail_count), 32'd1);
    check("t2_ffv", 32'(ff_valid), 32'd1);
    check("t2_ffa", 32'(ff_addr), 32'd1);
    check("t2_issues", 32'(issue_count), 32'd3);

    // Same program stopping on the first failure.
    start_run(1'b1);
    wait_done("t3");
    check("t3_test", 32'(test_count), 32'd2);
    check("t3_pass", 32'(pass_count), 32'd1);
    check("t3_fail", 32'(fail_count), 32'd1);
    check("t3_addr", 32'(prog_addr), 32'd1);
    check("t3_ffa", 32'(ff_addr), 32'd1);
    check("t3_issues", 32'(issue_count), 32'd2);

    // Flag masking: overflow checked matches, zero checked mismatches.
    clear_mem();
    cpu_flags   = 5'b01000;
    prog_mem[0] = addi(1, 0, 5);
    chk_mem[0]  = chk(1, 1, 5, 5'b01000, 5'b01010);
    prog_mem[1] = addi(2, 0, 6);
    chk_mem[1]  = chk(1, 2, 6, 5'b00010, 5'b01010);
    start_run(1'b0);
    wait_done("t4");
    check("t4_test", 32'(test_count), 32'd2);
    check("t4_pass", 32'(pass_count), 32'd1);
    check("t4_fail", 32'(fail_count), 32'd1);
    check("t4_ffa", 32'(ff_addr), 32'd1);
    cpu_flags = '0;

    // Asynchronous reset while the second instruction settles.
    load_two_step();
    start_run(1'b0);
    n = 0;
    while (!(instr_valid && test_count == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_pre_test", 32'(test_count), 32'd1);
    check("t5_pre_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_instr", cur_instr, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_addr", 32'(prog_addr), 32'd0);
    check("t5_test", 32'(test_count), 32'd0);
    check("t5_pass", 32'(pass_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run(1'b0);
    wait_done("t5r");
    check("t5r_test", 32'(test_count), 32'd2);
    check("t5r_pass", 32'(pass_count), 32'd2);
    check("t5r_issues", 32'(issue_count), 32'd2);

    // Full-depth program with no end marker; counters saturate at 3.
    clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      prog_mem[i] = addi(i + 1, i, 1);
      chk_mem[i]  = chk(1, i + 1, i + 1, 0, 0);
    end
    start_run(1'b0);
    wait_done("t6");
    check("t6_issues", 32'(issue_count), 32'd4);
    check("t6_addr", 32'(prog_addr), 32'd3);
    check("t6_test", 32'(test_count), 32'd3);
    check("t6_pass", 32'(pass_count), 32'd3);
    check("t6_fail", 32'(fail_count), 32'd0);

    // Every check wrong: fail saturates, first failure at address 0.
    for (int i = 0; i < DEPTH; i++) chk_mem[i] = chk(1, i + 1, 0, 0, 0);
    start_run(1'b0);
    wait_done("t7");
    check("t7_test", 32'(test_count), 32'd3);
    check("t7_pass", 32'(pass_count), 32'd0);
    check("t7_fail", 32'(fail_count), 32'd3);
    check("t7_ffv", 32'(ff_valid), 32'd1);
    check("t7_ffa", 32'(ff_addr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
